conv_stream_ctrl: RTL and testbench
===================================

# conv_stream_ctrl

Frame-level sequencer for the 3x3 line-buffered, padded convolution engine. On `start` it reads a raster-order image from a single-port pixel memory and issues one pixel to the engine every GAP cycles via a one-cycle `i_en` strobe. It captures each engine result on `o_en`, clamps it to 8 bits and writes it to a result memory. It pulses `done` after the last result is written. It replaces the free-running bench stimulus so the engine can sit inside a larger SoC datapath.

## Interface
- IMG_W, 512, image width in pixels
- IMG_H, 512, image height in pixels
- GAP, 16, cycles between successive `i_en` strobes; legal range 4..255
- AW, 18, pixel/result address width; IMG_W*IMG_H must be ≤ 2^AW
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request
- hold  in  1  stall request; while high, no new fetch begins
- busy  out  1  high from accepted `start` until the `done` pulse, inclusive
- done  out  1  one-cycle pulse when the frame is complete
- err  out  1  sticky overflow flag; cleared by `rst` or accepted `start`
- rd_en  out  1  pixel memory read strobe
- rd_addr  out  AW  pixel memory address
- rd_data  in  16  pixel data, valid the cycle after `rd_en`
- din  out  16  pixel to engine, valid while `i_en`=1
- i_en  out  1  engine input strobe
- o_en  in  1  engine result valid
- result  in  20  engine result, two's complement
- wr_en  out  1  result memory write strobe
- wr_addr  out  AW  result memory address
- wr_data  out  8  clamped result

## Operation
- N = IMG_W*IMG_H. `issue_cnt` and `out_cnt` are AW+1 bits wide and count 0..N.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DRAIN, FIN.
- IDLE → FETCH on `start`. Clears `issue_cnt`, `out_cnt` and `err`; sets `busy`. `start` in any other state is ignored.
- FETCH, when `hold`=0: assert `rd_en` with `rd_addr`=`issue_cnt[AW-1:0]`, then → ISSUE. When `hold`=1: stay in FETCH with no `rd_en`.
- ISSUE: register `din`<=`rd_data` and `i_en`<=1, so both are visible next cycle. Increment `issue_cnt`, then → WAIT.
- WAIT: count GAP-2 cycles. Then → FETCH if `issue_cnt`<N, else → DRAIN.
- DRAIN: wait until `out_cnt`==N, then → FIN.
- FIN: `done`=1 for one cycle, `busy` drops, → IDLE.
- `din` holds its last value when `i_en`=0.
- Writeback is independent of FSM state, but only active while `busy`.
  - On `o_en`=1 with `out_cnt`<N: next cycle `wr_en`=1, `wr_addr`=`out_cnt[AW-1:0]`, `wr_data`=clamp(result); `out_cnt`++.
  - Clamp: result<0 → 0; result>255 → 255; else result[7:0].
  - On `o_en`=1 with `out_cnt`==N, or `o_en` while not `busy`: no write, `err`<=1.
- Reset (any state, including mid-frame): next edge → IDLE. `busy`, `done`, `rd_en`, `i_en`, `wr_en` and `err` = 0. `din`, `rd_addr`, `wr_addr` and `wr_data` = 0. Both counters = 0.

## Timing
- All outputs are registered except `rd_en` and `rd_addr`, which are decoded from state FETCH and `issue_cnt`.
- Cycle F with `rd_en`=1 → `rd_data` is sampled at F+1 → `i_en`=1 at F+2.
- With `hold`=0, successive `i_en` strobes are exactly GAP cycles apart.
- A `hold` asserted in FETCH delays that strobe by the number of held cycles. `hold` has no effect in ISSUE, WAIT or DRAIN.
- `start` at cycle S: `busy`=1 at S+1, first `rd_en` at S+1, first `i_en` at S+3.
- `o_en` at cycle T → `wr_en` at T+1. Back-to-back `o_en` gives back-to-back writes; there is no buffering limit.
- The `o_en` that takes `out_cnt` to N: `wr_en` at T+1, DRAIN→FIN at T+1, `done`=1 at T+2.
- If the last result arrives before the last issue completes WAIT, WAIT goes straight to FIN, so `done` is 1 cycle after WAIT ends.
- A frame accepted in IDLE the cycle after FIN is legal; back-to-back frames have 1 idle cycle between them.

## Test plan
- Small frame: IMG_W=4, IMG_H=3, GAP=16, engine model returns din+1 with 5-cycle latency → 12 `i_en` strobes exactly 16 cycles apart. `wr_addr` runs 0..11 with `wr_data`=pixel+1. One `done` pulse; `busy` is low after it.
- Clamp: drive `result` = -7, 0, 255, 256, 0x7FFFF, 0x80000 → `wr_data` = 0, 0, 255, 255, 255, 0.
- Hold: assert `hold` for 10 cycles while in FETCH on pixel 5 → gap between `i_en` strobes 5 and 6 is 26 cycles. All other gaps are 16.
- Overflow: deliver 13 `o_en` for a 12-pixel frame, with the 13th after `done` → no 13th write and `err`=1. The next `start` clears `err`.
- Reset mid-frame: `rst` at pixel 7 → next cycle all strobes, `busy` and counters are 0. A fresh `start` restarts from `rd_addr`=0.
- Ignored start plus full size: pulse `start` while `busy` → no restart. Then run the default 512x512, GAP=16 frame → 262144 writes, final `wr_addr`=262143, `done` once.

Source files
------------

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: frame sequencer feeding a 3x3 conv engine from pixel memory and
// writing clamped results back to a result memory.
module conv_stream_ctrl #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int GAP   = 16,
    parameter int AW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic [15:0]   din,
    output logic          i_en,
    input  logic          o_en,
    input  logic [19:0]   result,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DRAIN, FIN} state_t;

    localparam int          NI    = IMG_W * IMG_H;
    localparam logic [AW:0] N     = (AW+1)'(NI);
    localparam logic [7:0]  WLAST = 8'(GAP - 3);

    state_t      state_q, state_d;
    logic [AW:0] issue_cnt_q, out_cnt_q;
    logic [7:0]  wcnt_q;
    logic        wr_ok, ovf;
    logic [7:0]  clamp;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (!hold) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            // FETCH+ISSUE+(GAP-2) WAIT cycles gives exactly GAP cycles per pixel
            WAIT:    if (wcnt_q == WLAST)
                         state_d = issue_cnt_q < N ? FETCH : (out_cnt_q == N ? FIN : DRAIN);
            DRAIN:   if (out_cnt_q == N) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_en   = (state_q == FETCH) && !hold;
    assign rd_addr = issue_cnt_q[AW-1:0];
    assign wr_ok   = o_en && busy && (out_cnt_q < N);
    assign ovf     = o_en && !wr_ok;
    assign clamp   = result[19] ? 8'd0 : (|result[18:8] ? 8'hFF : result[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            i_en        <= 1'b0;
            wr_en       <= 1'b0;
            din         <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q <= state_d;
            busy    <= state_d != IDLE;
            done    <= state_d == FIN;
            i_en    <= state_q == ISSUE;
            wr_en   <= wr_ok;
            wcnt_q  <= (state_q == WAIT) ? wcnt_q + 8'd1 : 8'd0;
            if (state_q == ISSUE) begin
                din         <= rd_data;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (wr_ok) begin
                wr_addr   <= out_cnt_q[AW-1:0];
                wr_data   <= clamp;
                out_cnt_q <= out_cnt_q + 1'b1;
            end
            if (state_q == IDLE && start) begin
                issue_cnt_q <= '0;
                out_cnt_q   <= '0;
                err         <= 1'b0;
            end else if (ovf) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: directed bench for conv_stream_ctrl on a 4x3 frame with a
// 5-cycle din+1 engine model and a registered pixel memory.
module tb_conv_stream_ctrl;
    localparam int W = 4, H = 3, G = 16, A = 4, NP = W * H;

    logic clk = 1'b0;
    logic rst, start, hold, o_en;
    logic busy, done, err, rd_en, i_en, wr_en;
    logic [A-1:0] rd_addr, wr_addr;
    logic [15:0] rd_data, din;
    logic [19:0] result;
    logic [7:0] wr_data;

    logic man, m_oen;
    logic [19:0] m_res;
    logic [4:0] ep = '0;
    logic [15:0] dp [5];
    logic [15:0] mem [16];
    int cyc = 0, done_n = 0, pass = 0, total = 0;
    int ien_t [$];
    logic [A-1:0] wa [$];
    logic [7:0] wd [$];

    typedef struct {logic [19:0] res; logic [7:0] exp;} cvec_t;
    cvec_t cv [6];

    conv_stream_ctrl #(.IMG_W(W), .IMG_H(H), .GAP(G), .AW(A)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
        .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .din(din),
        .i_en(i_en), .o_en(o_en), .result(result), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
        ep    <= {ep[3:0], i_en};
        dp[0] <= din;
        for (int i = 1; i < 5; i++) dp[i] <= dp[i-1];
    end

    assign o_en   = man ? m_oen : ep[4];
    assign result = man ? m_res : {4'b0, dp[4]} + 20'd1;

    always @(negedge clk) begin
        if (i_en) ien_t.push_back(cyc);
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
        if (done) done_n++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        else pass++;
    endtask

    task automatic start_frame();
        ien_t.delete();
        wa.delete();
        wd.delete();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n0 = done_n;
        for (int i = 0; i < 600 && done_n == n0; i++) step();
        chk({nm, "_done"}, done_n - n0, 1);
        step();
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_done_single"}, done_n - n0, 1);
    endtask

    task automatic chk_frame(input string nm, input int hold_idx);
        chk({nm, "_strobes"}, ien_t.size(), NP);
        for (int i = 0; i + 1 < ien_t.size(); i++)
            chk($sformatf("%s_gap%0d", nm, i), ien_t[i+1] - ien_t[i], (i == hold_idx) ? 26 : 16);
        chk({nm, "_writes"}, wa.size(), NP);
        for (int i = 0; i < wa.size() && i < NP; i++) begin
            chk($sformatf("%s_waddr%0d", nm, i), wa[i], i);
            chk($sformatf("%s_wdata%0d", nm, i), wd[i], 8'(mem[i] + 16'd1));
        end
        chk({nm, "_err"}, err, 0);
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < 400 && ien_t.size() < n; i++) step();
        chk($sformatf("reach_strobe%0d", n), ien_t.size() >= n, 1);
    endtask

    initial begin
        cv[0] = '{20'hFFFF9, 8'd0};
        cv[1] = '{20'h00000, 8'd0};
        cv[2] = '{20'h000FF, 8'd255};
        cv[3] = '{20'h00100, 8'd255};
        cv[4] = '{20'h7FFFF, 8'd255};
        cv[5] = '{20'h80000, 8'd0};
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 7 + 10);
        rst = 1'b1; start = 1'b0; hold = 1'b0; man = 1'b0; m_oen = 1'b0; m_res = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_i_en", i_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_din", din, 0);

        // frame 1: start latency, then full-frame checks
        start_frame();
        chk("f1_busy_s1", busy, 1);
        chk("f1_rd_en_s1", rd_en, 1);
        chk("f1_rd_addr_s1", rd_addr, 0);
        step();
        chk("f1_i_en_s2", i_en, 0);
        step();
        chk("f1_i_en_s3", i_en, 1);
        chk("f1_din_s3", din, mem[0]);
        wait_done("f1");
        chk_frame("f1", -1);

        // frame 2: hold through 10 FETCH cycles before pixel 5
        start_frame();
        wait_strobes(5);
        hold = 1'b1;
        repeat (24) step();
        hold = 1'b0;
        wait_done("f2");
        chk_frame("f2", 4);

        // overflow: extra result after done
        man = 1'b1; m_oen = 1'b1; m_res = 20'd5;
        step();
        m_oen = 1'b0; man = 1'b0;
        chk("ovf_no_write", wr_en, 0);
        chk("ovf_err", err, 1);

        // frame 3: start clears err, start while busy is ignored
        start_frame();
        chk("f3_err_clear", err, 0);
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("f3");
        chk_frame("f3", -1);

        // frame 4: reset mid-frame
        start_frame();
        wait_strobes(7);
        rst = 1'b1;
        step();
        chk("mrst_busy", busy, 0);
        chk("mrst_i_en", i_en, 0);
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_rd_en", rd_en, 0);
        chk("mrst_rd_addr", rd_addr, 0);
        chk("mrst_wr_addr", wr_addr, 0);
        chk("mrst_din", din, 0);
        rst = 1'b0;
        repeat (10) step();
        start_frame();
        chk("f5_rd_en", rd_en, 1);
        chk("f5_rd_addr", rd_addr, 0);
        wait_done("f5");
        chk_frame("f5", -1);

        // clamp vectors driven directly on the result port
        man = 1'b1;
        start_frame();
        for (int i = 0; i < 6; i++) begin
            m_res = cv[i].res;
            m_oen = 1'b1;
            step();
            chk($sformatf("clamp%0d_wr_en", i), wr_en, 1);
            chk($sformatf("clamp%0d_addr", i), wr_addr, i);
            chk($sformatf("clamp%0d_data", i), wr_data, cv[i].exp);
        end
        m_oen = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        man = 1'b0;
        step();
        chk("end_busy", busy, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
